// File: rtl/aes_job_sequencer.sv
// aes_job_sequencer: releases key/rc/text bytes per job into the AES-256 core, frames its output stream and counts blocks.
// Optional feature macro: AES_KEY_REUSE_EN (skip KEY/RC when software asks to reuse the previously loaded key).
module aes_job_sequencer #(
    parameter int TEXT_BYTES   = 16,
    parameter int KEY_BYTES    = 32,
    parameter int RC_BYTES     = 7,
    parameter int OUT_BYTES    = 16,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        key_reuse,
    input  logic        text_src_valid,
    input  logic        key_src_valid,
    input  logic        rc_src_valid,
    output logic        text_src_enr,
    output logic        key_src_enr,
    output logic        rc_src_enr,
    input  logic        text_dst_full,
    input  logic        key_dst_full,
    input  logic        rc_dst_full,
    output logic        text_dst_wr,
    output logic        key_dst_wr,
    output logic        rc_dst_wr,
    input  logic        out_valid,
    input  logic        m_tready,
    output logic        out_enr,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        busy,
    output logic [2:0]  inflight,
    output logic [15:0] blocks_done
);
    typedef enum logic [1:0] {IDLE, KEY, RC, TEXT} state_t;
    state_t state, state_nx;
    logic [7:0] cnt, ocnt, last_cnt;
    logic cur_valid, cur_full, wr, phase_done, start, reuse_ok, text_done, dec;
`ifdef AES_KEY_REUSE_EN
    logic valid_key;
    // remember that a complete key has been loaded into the core
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid_key <= 1'b0;
        else if (state == KEY && phase_done) valid_key <= 1'b1;
    assign reuse_ok = key_reuse & valid_key;
`else
    logic unused_key_reuse;
    assign unused_key_reuse = key_reuse;
    assign reuse_ok = 1'b0;
`endif
    // phase stream selection, byte strobes, output framing and next state
    always_comb begin
        state_nx    = state;
        cur_valid   = state == KEY ? key_src_valid : state == RC ? rc_src_valid : text_src_valid;
        cur_full    = state == KEY ? key_dst_full : state == RC ? rc_dst_full : text_dst_full;
        last_cnt    = state == KEY ? 8'(KEY_BYTES - 1) : state == RC ? 8'(RC_BYTES - 1) : 8'(TEXT_BYTES - 1);
        wr          = (state != IDLE) & cur_valid & ~cur_full;
        phase_done  = wr & (cnt == last_cnt);
        text_done   = (state == TEXT) & phase_done;
        start       = en & text_src_valid & (inflight < 3'(MAX_INFLIGHT));
        key_src_enr = (state == KEY) & ~key_dst_full;
        rc_src_enr  = (state == RC) & ~rc_dst_full;
        text_src_enr = (state == TEXT) & ~text_dst_full;
        key_dst_wr  = (state == KEY) & wr;
        rc_dst_wr   = (state == RC) & wr;
        text_dst_wr = (state == TEXT) & wr;
        out_enr     = m_tready & rst_n;
        m_tvalid    = out_valid & m_tready & rst_n;
        m_tlast     = m_tvalid & (ocnt == 8'(OUT_BYTES - 1));
        dec         = m_tlast & (inflight != 3'd0);
        busy        = (state != IDLE) | (inflight != 3'd0);
        if (state == IDLE) state_nx = start ? (reuse_ok ? TEXT : KEY) : IDLE;
        else if (phase_done) state_nx = state == KEY ? RC : state == RC ? TEXT : IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // byte counters, in-flight tracking and block statistics
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt         <= '0;
            ocnt        <= '0;
            inflight    <= '0;
            blocks_done <= '0;
        end else begin
            cnt         <= (state == IDLE || phase_done) ? 8'd0 : wr ? cnt + 8'd1 : cnt;
            ocnt        <= m_tlast ? 8'd0 : m_tvalid ? ocnt + 8'd1 : ocnt;
            inflight    <= inflight + 3'(text_done) - 3'(dec);
            blocks_done <= blocks_done + 16'(m_tlast);
        end
endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb_aes_job_sequencer: directed plus randomized checks of aes_job_sequencer against a job-level byte-position model.
module tb_aes_job_sequencer;
    localparam int K = 32, R = 7, T = 16, O = 16, MI = 2;
`ifdef AES_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif
    logic clk = 0, rst_n = 0, en = 0, key_reuse = 0;
    logic text_src_valid = 1, key_src_valid = 1, rc_src_valid = 1;
    logic text_dst_full = 0, key_dst_full = 0, rc_dst_full = 0;
    logic out_valid = 0, m_tready = 1;
    logic text_src_enr, key_src_enr, rc_src_enr, text_dst_wr, key_dst_wr, rc_dst_wr;
    logic out_enr, m_tvalid, m_tlast, busy;
    logic [2:0] inflight;
    logic [15:0] blocks_done;
    logic [9:0] outs;
    int nvec = 0, nerr = 0, cyc = 0;
    int tot_key = 0, tot_rc = 0, tot_text = 0, tot_tlast = 0;
    int last_key_cyc = 0, last_rc_cyc = 0, last_text_cyc = 0, last_tlast_cyc = 0;
    bit m_active, m_vkey;
    int m_pos, m_infl, m_ocnt;
    logic [15:0] m_blk;

    aes_job_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .key_reuse(key_reuse),
        .text_src_valid(text_src_valid), .key_src_valid(key_src_valid), .rc_src_valid(rc_src_valid),
        .text_src_enr(text_src_enr), .key_src_enr(key_src_enr), .rc_src_enr(rc_src_enr),
        .text_dst_full(text_dst_full), .key_dst_full(key_dst_full), .rc_dst_full(rc_dst_full),
        .text_dst_wr(text_dst_wr), .key_dst_wr(key_dst_wr), .rc_dst_wr(rc_dst_wr),
        .out_valid(out_valid), .m_tready(m_tready), .out_enr(out_enr), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .busy(busy), .inflight(inflight), .blocks_done(blocks_done)
    );

    assign outs = {text_src_enr, key_src_enr, rc_src_enr, text_dst_wr, key_dst_wr, rc_dst_wr,
                   out_enr, m_tvalid, m_tlast, busy};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // per-cycle comparison against the job-position model, then model advance
    always @(negedge clk) begin
        int s;
        bit wr, tv, tl, inc;
        logic [9:0] e;
        if (!rst_n) begin
            m_active = 0; m_vkey = 0; m_pos = 0; m_infl = 0; m_ocnt = 0; m_blk = 0;
            chk("reset_outputs", 32'(outs), 32'd0);
            chk("reset_inflight", 32'(inflight), 32'd0);
            chk("reset_blocks_done", 32'(blocks_done), 32'd0);
        end else begin
            s  = !m_active ? 3 : m_pos < K ? 1 : m_pos < K + R ? 2 : 0;
            wr = s == 1 ? (key_src_valid && !key_dst_full) : s == 2 ? (rc_src_valid && !rc_dst_full) :
                 s == 0 ? (text_src_valid && !text_dst_full) : 1'b0;
            tv = out_valid && m_tready;
            tl = tv && m_ocnt == O - 1;
            e  = {s == 0 && !text_dst_full, s == 1 && !key_dst_full, s == 2 && !rc_dst_full,
                  s == 0 && wr, s == 1 && wr, s == 2 && wr, m_tready, tv, tl, m_active || m_infl != 0};
            chk("outputs", 32'(outs), 32'(e));
            chk("inflight", 32'(inflight), 32'(m_infl));
            chk("blocks_done", 32'(blocks_done), 32'(m_blk));
            if (key_dst_wr) begin tot_key++; last_key_cyc = cyc; end
            if (rc_dst_wr) begin tot_rc++; last_rc_cyc = cyc; end
            if (text_dst_wr) begin tot_text++; last_text_cyc = cyc; end
            if (m_tlast) begin tot_tlast++; last_tlast_cyc = cyc; end
            inc = 0;
            if (m_active) begin
                if (wr) begin
                    m_pos++;
                    if (m_pos == K) m_vkey = 1;
                    if (m_pos == K + R + T) begin m_active = 0; inc = 1; end
                end
            end else if (en && text_src_valid && m_infl < MI) begin
                m_active = 1;
                m_pos = (REUSE && key_reuse && m_vkey) ? K + R : 0;
            end
            if (tv) m_ocnt = tl ? 0 : m_ocnt + 1;
            if (tl) m_blk++;
            m_infl = m_infl + int'(inc) - ((tl && m_infl > 0) ? 1 : 0);
        end
        cyc++;
    end

    task automatic run_job(input bit reuse, output int c0);
        int t0 = tot_text;
        c0 = cyc; en = 1; key_reuse = reuse;
        step();
        en = 0; key_reuse = 0;
        for (int i = 0; i < 400 && tot_text - t0 < T; i++) step();
        chk("job_complete", 32'(tot_text - t0), 32'(T));
    endtask

    task automatic drain();
        out_valid = 1;
        repeat (O) step();
        out_valid = 0;
    endtask

    initial begin
        int c0, k0, r0, t0, tl0, t;
        repeat (3) step();
        rst_n = 1;
        step();
        // single job at full throughput
        k0 = tot_key; r0 = tot_rc; t0 = tot_text;
        run_job(0, c0);
        chk("job1_key_writes", 32'(tot_key - k0), 32'd32);
        chk("job1_rc_writes", 32'(tot_rc - r0), 32'd7);
        chk("job1_length", 32'(last_text_cyc - c0), 32'd55);
        chk("job1_inflight", 32'(inflight), 32'd1);
        tl0 = tot_tlast;
        drain();
        chk("job1_tlast_count", 32'(tot_tlast - tl0), 32'd1);
        chk("job1_tlast_on_16th", 32'(last_tlast_cyc), 32'(cyc - 1));
        chk("job1_inflight_after", 32'(inflight), 32'd0);
        chk("job1_blocks_done", 32'(blocks_done), 32'd1);
        // key port backpressure every other cycle
        k0 = tot_key; r0 = tot_rc; t0 = tot_text;
        c0 = cyc; en = 1; key_dst_full = 0;
        step();
        en = 0;
        for (int i = 0; i < 200 && tot_rc == r0; i++) begin
            key_dst_full = ~key_dst_full;
            step();
        end
        key_dst_full = 0;
        chk("bp_key_writes", 32'(tot_key - k0), 32'd32);
        chk("bp_first_rc_cycle", 32'(last_rc_cyc - c0), 32'd65);
        for (int i = 0; i < 100 && tot_text - t0 < T; i++) step();
        drain();
        // in-flight limit with a stalled sink
        k0 = tot_key; t0 = tot_text; m_tready = 0; en = 1;
        repeat (200) step();
        chk("limit_inflight", 32'(inflight), 32'd2);
        chk("limit_busy", 32'(busy), 32'd1);
        chk("limit_key_writes", 32'(tot_key - k0), 32'd64);
        tl0 = tot_tlast; m_tready = 1; out_valid = 1;
        for (int i = 0; i < 40 && tot_tlast == tl0; i++) step();
        t = last_tlast_cyc; k0 = tot_key;
        for (int i = 0; i < 10 && tot_key == k0; i++) step();
        en = 0;
        chk("limit_restart_cycle", 32'(last_key_cyc - t), 32'd2);
        while (cyc < t + 17) step();
        out_valid = 0;
        for (int i = 0; i < 300 && tot_text - t0 < 3 * T; i++) step();
        drain();
        chk("limit_blocks_done", 32'(blocks_done), 32'd5);
        // TEXT exit coinciding with the last output beat
        run_job(0, c0);
        c0 = cyc; en = 1;
        step();
        en = 0;
        repeat (39) step();
        drain();
        chk("simul_same_cycle", 32'(last_tlast_cyc), 32'(last_text_cyc));
        chk("simul_inflight", 32'(inflight), 32'd1);
        chk("simul_blocks_done", 32'(blocks_done), 32'd6);
        drain();
        // reset in the middle of the RC phase with a block outstanding
        run_job(0, c0);
        r0 = tot_rc; en = 1;
        step();
        en = 0;
        for (int i = 0; i < 100 && tot_rc == r0; i++) step();
        rst_n = 0; out_valid = 1;
        #1;
        chk("rst_mid_outputs", 32'(outs), 32'd0);
        chk("rst_mid_inflight", 32'(inflight), 32'd0);
        chk("rst_mid_blocks", 32'(blocks_done), 32'd0);
        step();
        out_valid = 0;
        step();
        rst_n = 1;
        step();
        // key reuse on the second job
        run_job(0, c0);
        drain();
        k0 = tot_key; r0 = tot_rc; t0 = tot_text;
        run_job(1, c0);
        chk("reuse_key_writes", 32'(tot_key - k0), REUSE ? 32'd0 : 32'd32);
        chk("reuse_rc_writes", 32'(tot_rc - r0), REUSE ? 32'd0 : 32'd7);
        chk("reuse_length", 32'(last_text_cyc - c0), REUSE ? 32'd16 : 32'd55);
        drain();
        chk("reuse_blocks_done", 32'(blocks_done), 32'd2);
        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            en = $urandom_range(0, 9) < 7;
            key_reuse = $urandom_range(0, 1) == 1;
            text_src_valid = $urandom_range(0, 9) < 8;
            key_src_valid = $urandom_range(0, 9) < 8;
            rc_src_valid = $urandom_range(0, 9) < 8;
            text_dst_full = $urandom_range(0, 9) < 2;
            key_dst_full = $urandom_range(0, 9) < 2;
            rc_dst_full = $urandom_range(0, 9) < 2;
            out_valid = $urandom_range(0, 1) == 1;
            m_tready = $urandom_range(0, 9) < 7;
            rst_n = $urandom_range(0, 1999) != 0;
            step();
        end
        rst_n = 1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
